// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcode names, instruction field
// positions, issue FSM states and the decoded-instruction struct.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001
  } aluop_e;

  localparam int INSTR_W    = 16;
  localparam int REG_IDX_W  = 3;
  localparam int IMM_W      = 6;
  localparam int F_OPC_LSB  = 13;
  localparam int F_OP2SEL   = 12;
  localparam int F_RD_LSB   = 9;
  localparam int F_RS1_LSB  = 6;
  localparam int F_RS2_LSB  = 3;
  localparam int F_IMM_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC
  } issue_state_e;

  typedef struct packed {
    logic [2:0]           aluopc;
    logic                 op2sel;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [IMM_W-1:0]     imm6;
  } instr_t;

  // imm6 overlaps the rs2 field; op2sel decides which one is meaningful.
  function automatic instr_t decode(input logic [INSTR_W-1:0] iw);
    instr_t d;
    d.aluopc = iw[F_OPC_LSB +: 3];
    d.op2sel = iw[F_OP2SEL];
    d.rd     = iw[F_RD_LSB  +: REG_IDX_W];
    d.rs1    = iw[F_RS1_LSB +: REG_IDX_W];
    d.rs2    = iw[F_RS2_LSB +: REG_IDX_W];
    d.imm6   = iw[F_IMM_LSB +: IMM_W];
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NUM_REGS x REG_WIDTH register file: two operand read ports, one debug read
// port, one synchronous write port; r0 is hardwired to zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int REG_WIDTH = 16,
  parameter int NUM_REGS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rd_addr_a,
  output logic [REG_WIDTH-1:0] rd_data_a,
  input  logic [REG_IDX_W-1:0] rd_addr_b,
  output logic [REG_WIDTH-1:0] rd_data_b,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [REG_WIDTH-1:0] dbg_data,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [REG_WIDTH-1:0] wr_data
);

  localparam int AW = $clog2(NUM_REGS);

  logic [REG_WIDTH-1:0] regs [NUM_REGS];

  // NOTE: the array is reset explicitly, which forces flops rather than a RAM
  // macro; acceptable at 8 entries and required so software sees all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a[AW-1:0]];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b[AW-1:0]];
  assign dbg_data  = (dbg_addr  == '0) ? '0 : regs[dbg_addr[AW-1:0]];

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage feeding a combinational ALU and writing its result back.
// Define ALU_ISSUE_FASTPATH_EN to drop the READ state (2-cycle issue).
module alu_issue
  import alu_pkg::*;
#(
  parameter int REG_WIDTH = 16,
  parameter int NUM_REGS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [15:0]          instr,
  output logic [REG_WIDTH-1:0] alu_ra,
  output logic [REG_WIDTH-1:0] alu_rb,
  output logic [2:0]           alu_aluopc,
  output logic                 alu_op2sel,
  output logic                 alu_flagcin,
  input  logic [REG_WIDTH-1:0] alu_out,
  input  logic                 alu_flagc,
  input  logic                 alu_flagv,
  output logic                 wb_valid,
  output logic [2:0]           wb_rd,
  output logic [REG_WIDTH-1:0] wb_data,
  output logic                 flag_c,
  output logic                 flag_v,
  input  logic [2:0]           dbg_addr,
  output logic [REG_WIDTH-1:0] dbg_data
);

  issue_state_e         state, state_next;
  instr_t               dec;
  logic                 accept;
  logic                 load_ops;
  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_rd;
  logic [REG_WIDTH-1:0] rs1_data, rs2_data, opb;

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign alu_flagcin = flag_c;
  assign wr_en       = (state == EXEC);

`ifdef ALU_ISSUE_FASTPATH_EN
  localparam issue_state_e AFTER_IDLE = EXEC;
  logic [REG_IDX_W-1:0] rd_q;

  // Operands come straight from the live instruction at the handshake edge.
  assign dec      = decode(instr);
  assign load_ops = accept;
  assign wr_rd    = rd_q;

  always_ff @(posedge clk) begin
    if (rst)         rd_q <= '0;
    else if (accept) rd_q <= dec.rd;
  end
`else
  localparam issue_state_e AFTER_IDLE = READ;
  instr_t instr_q;

  assign dec      = instr_q;
  assign load_ops = (state == READ);
  assign wr_rd    = instr_q.rd;

  always_ff @(posedge clk) begin
    if (rst)         instr_q <= '0;
    else if (accept) instr_q <= decode(instr);
  end
`endif

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = AFTER_IDLE;
      READ:    state_next = EXEC;
      EXEC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign opb = dec.op2sel ? REG_WIDTH'(dec.imm6) : rs2_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ra     <= '0;
      alu_rb     <= '0;
      alu_aluopc <= '0;
      alu_op2sel <= 1'b0;
    end else if (load_ops) begin
      alu_ra     <= rs1_data;
      alu_rb     <= opb;
      alu_aluopc <= dec.aluopc;
      alu_op2sel <= dec.op2sel;
    end
  end

  // Writeback and flag update share the EXEC edge; r0 filtering lives in the
  // register file so the pulse still reports wb_rd=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
    end else begin
      wb_valid <= wr_en;
      if (wr_en) begin
        wb_rd   <= wr_rd;
        wb_data <= alu_out;
        flag_c  <= alu_flagc;
        flag_v  <= alu_flagv;
      end
    end
  end

  alu_regfile #(
    .REG_WIDTH (REG_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (dec.rs1),
    .rd_data_a (rs1_data),
    .rd_addr_b (dec.rs2),
    .rd_data_b (rs2_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_rd),
    .wr_data   (alu_out)
  );

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU, register-file model,
// directed scenarios plus randomized instructions.
module tb_alu_issue;
  import alu_pkg::*;

`ifdef ALU_ISSUE_FASTPATH_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [15:0] alu_ra, alu_rb, alu_out, wb_data, dbg_data;
  logic [2:0]  alu_aluopc, wb_rd;
  logic [2:0]  dbg_addr = '0;
  logic        alu_op2sel, alu_flagcin, alu_flagc, alu_flagv;
  logic        wb_valid, flag_c, flag_v;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_regs [8];
  logic        model_c, model_v;

  always #5 clk = ~clk;

  alu_issue #(.REG_WIDTH(16), .NUM_REGS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_ra      (alu_ra),
    .alu_rb      (alu_rb),
    .alu_aluopc  (alu_aluopc),
    .alu_op2sel  (alu_op2sel),
    .alu_flagcin (alu_flagcin),
    .alu_out     (alu_out),
    .alu_flagc   (alu_flagc),
    .alu_flagv   (alu_flagv),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flag_c      (flag_c),
    .flag_v      (flag_v),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Returns {carry, overflow, result}.
  function automatic logic [17:0] alu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (aluop_e'(op))
      ALU_ADD: begin
        r = {1'b0, a} + {1'b0, b};
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      ALU_SUB: begin
        r = {1'b0, a} - {1'b0, b};
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      default: ;
    endcase
    return {r[16], v, r[15:0]};
  endfunction

  always_comb {alu_flagc, alu_flagv, alu_out} = alu_model(alu_aluopc, alu_ra, alu_rb);

  function automatic logic [15:0] mk(input logic [2:0] op, input logic sel, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [5:0] low6);
    return {op, sel, rd, rs1, low6};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model result of an instruction given the current architectural state;
  // also returns the operands the ALU should see.
  task automatic predict(input logic [15:0] iw, output logic [15:0] a, output logic [15:0] b,
                         output logic [17:0] res);
    a   = model_regs[iw[8:6]];
    b   = iw[12] ? {10'b0, iw[5:0]} : model_regs[iw[5:3]];
    res = alu_model(iw[15:13], a, b);
  endtask

  task automatic commit(input logic [2:0] rd, input logic [17:0] res);
    if (rd != 3'd0) model_regs[rd] = res[15:0];
    model_c = res[17];
    model_v = res[16];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = '0;
    model_c = 1'b0;
    model_v = 1'b0;
  endtask

  // Called and returns at the phase #1 after a rising edge, with the DUT idle.
  task automatic issue(input logic [15:0] iw);
    logic [15:0] a, b;
    logic [17:0] res;
    int          n;
    predict(iw, a, b, res);
    n = 0;
    while (!instr_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = iw;
    @(posedge clk); #1;
    instr_valid = 1'($urandom);
    instr       = 16'($urandom);
    check("ready_busy", instr_ready, 0);
`ifndef ALU_ISSUE_FASTPATH_EN
    check("wb_early_read", wb_valid, 0);
    @(posedge clk); #1;
    check("ready_exec", instr_ready, 0);
`endif
    instr_valid = 1'b0;
    check("alu_ra", alu_ra, a);
    check("alu_rb", alu_rb, b);
    check("alu_aluopc", alu_aluopc, iw[15:13]);
    check("alu_op2sel", alu_op2sel, iw[12]);
    check("alu_flagcin", alu_flagcin, model_c);
    check("wb_early_exec", wb_valid, 0);
    @(posedge clk); #1;
    check("wb_valid", wb_valid, 1);
    check("wb_rd", wb_rd, iw[11:9]);
    check("wb_data", wb_data, res[15:0]);
    check("flag_c", flag_c, res[17]);
    check("flag_v", flag_v, res[16]);
    check("ready_after", instr_ready, 1);
    commit(iw[11:9], res);
    dbg_addr = iw[11:9];
    #1;
    check("dbg_rd", dbg_data, model_regs[iw[11:9]]);
  endtask

  // instr_valid held high for four instructions; pulses must be LAT+1 apart.
  task automatic burst();
    logic [15:0] iw, a, b;
    logic [17:0] res;
    logic [2:0]  q_rd   [$];
    logic [15:0] q_data [$];
    int issued = 0, pulses = 0, last = 0;
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (instr_ready) begin
        if (issued < 4) begin
          iw = mk(3'($urandom_range(0, 1)), 1'b1, 3'(issued + 1), 3'(issued), 6'($urandom));
          predict(iw, a, b, res);
          commit(iw[11:9], res);
          q_rd.push_back(iw[11:9]);
          q_data.push_back(res[15:0]);
          instr = iw;
          issued++;
        end else begin
          instr_valid = 1'b0;
        end
      end else begin
        instr = 16'($urandom);
      end
      @(posedge clk); #1;
      if (wb_valid) begin
        pulses++;
        if (q_rd.size() > 0) begin
          check("burst_rd", wb_rd, q_rd.pop_front());
          check("burst_data", wb_data, q_data.pop_front());
        end
        if (pulses > 1) check("burst_spacing", cyc - last, LAT + 1);
        last = cyc;
      end
    end
    instr_valid = 1'b0;
    check("burst_pulses", pulses, 4);
    check("burst_flag_c", flag_c, model_c);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1;
      check("burst_dbg", dbg_data, model_regs[r]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] iw;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_ready", instr_ready, 1);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_flag_c", flag_c, 0);
    check("rst_flag_v", flag_v, 0);
    check("rst_alu_ra", alu_ra, 0);
    check("rst_alu_rb", alu_rb, 0);
    check("rst_aluopc", alu_aluopc, 0);
    check("rst_op2sel", alu_op2sel, 0);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1;
      check("rst_dbg", dbg_data, 0);
    end

    // ADD r1,r0,#5
    issue(16'h1205);
    check("r1_is_5", dbg_data, 16'd5);
    // ADD r0,r0,#7: pulse with rd 0, r0 stays zero
    issue(mk(ALU_ADD, 1'b1, 3'd0, 3'd0, 6'd7));
    check("r0_zero", dbg_data, 16'd0);
    // ADD r2,r0,#63 then SUB r3,r1,r2 (borrow)
    issue(mk(ALU_ADD, 1'b1, 3'd2, 3'd0, 6'd63));
    issue(mk(ALU_SUB, 1'b0, 3'd3, 3'd1, {3'd2, 3'd0}));
    check("r3_value", dbg_data, 16'hFFC6);
    check("sub_borrow", flag_c, 1);
    // Next issue must see the borrow as carry-in (checked inside issue)
    issue(mk(ALU_ADD, 1'b0, 3'd6, 3'd3, {3'd1, 3'd0}));

    // Reset while ADD r4,r0,#9 is in EXEC
    instr_valid = 1'b1;
    instr       = mk(ALU_ADD, 1'b1, 3'd4, 3'd0, 6'd9);
    @(posedge clk); #1;
    instr_valid = 1'b0;
`ifndef ALU_ISSUE_FASTPATH_EN
    @(posedge clk); #1;
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("mid_rst_wb", wb_valid, 0);
    check("mid_rst_ready", instr_ready, 1);
    check("mid_rst_flag_c", flag_c, 0);
    check("mid_rst_flag_v", flag_v, 0);
    dbg_addr = 3'd4;
    #1;
    check("mid_rst_r4", dbg_data, 0);
    dbg_addr = 3'd3;
    #1;
    check("mid_rst_r3", dbg_data, 0);
    @(posedge clk); #1;
    check("mid_rst_no_wb", wb_valid, 0);

    // Dependent pair: r1=5 then r5=r1+1
    issue(16'h1205);
    issue(mk(ALU_ADD, 1'b1, 3'd5, 3'd1, 6'd1));
    check("r5_is_6", dbg_data, 16'd6);

    burst();

    for (int k = 0; k < 40; k++) begin
      iw = 16'($urandom);
      if ($urandom_range(0, 3) != 0) iw[15:13] = 3'($urandom_range(0, 1));
      issue(iw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
